// File: rtl/hb_decim_2.sv
// hb_decim_2: decimate-by-2 stage following the half-band filter.
//
// Keeps one of every two strobed input samples, applies a power-of-two gain
// with saturation and emits a one-cycle clk_en_out strobe at half the input
// sample rate (intended to drive the next filter stage's clk_en).
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high reset
//   clk_en     - input sample strobe; x_in valid when high
//   x_in       - signed input sample (DATA_W)
//   phase_sel  - which decimation phase (0/1) is kept
//   resync     - single-cycle pulse, realigns the decimation phase
//   gain_shl   - left-shift gain, sampled together with the kept sample
//   sat_clr    - clears the sticky sat_flag
//   y          - registered, gained, saturated output sample
//   clk_en_out - one-cycle pulse while y carries a new sample
//   sat_flag   - sticky, set whenever an output sample was clipped
module hb_decim_2 #(
  parameter int unsigned DATA_W  = 18,
  parameter int unsigned SHIFT_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic signed [DATA_W-1:0]  x_in,
  input  logic                      phase_sel,
  input  logic                      resync,
  input  logic        [SHIFT_W-1:0] gain_shl,
  input  logic                      sat_clr,
  output logic signed [DATA_W-1:0]  y,
  output logic                      clk_en_out,
  output logic                      sat_flag
);

  // Largest possible shift and the width that holds any shifted sample losslessly.
  localparam int unsigned MaxShift = 2**SHIFT_W - 1;
  localparam int unsigned ExtW     = DATA_W + MaxShift;

  // Output range limits expressed in the extended width.
  localparam logic signed [ExtW-1:0] PosLim = {{(MaxShift + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ExtW-1:0] NegLim = {{(MaxShift + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic                     phase_q, phase_d;
  logic                     eff_phase;
  logic                     capture;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [DATA_W-1:0] s1_x_q, s1_x_d;
  logic        [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
  logic signed [ExtW-1:0]   ext;
  logic signed [ExtW-1:0]   shifted;
  logic signed [DATA_W-1:0] sat_val;
  logic                     clip;
  logic signed [DATA_W-1:0] y_q, y_d;
  logic                     out_q, out_d;
  logic                     sat_q, sat_d;

  // Phase tracking and stage-1 capture. A resync makes the current strobe
  // (if any) phase 0, otherwise the next strobe becomes phase 0.
  always_comb begin
    eff_phase  = resync ? 1'b0 : phase_q;
    phase_d    = resync ? clk_en : (clk_en ? ~phase_q : phase_q);
    capture    = clk_en & (eff_phase == phase_sel);
    s1_valid_d = capture;
    s1_x_d     = capture ? x_in : s1_x_q;
    s1_shift_d = capture ? gain_shl : s1_shift_q;
  end

  // Stage 2: shift in a width that cannot overflow, then clamp to DATA_W.
  always_comb begin
    ext     = {{MaxShift{s1_x_q[DATA_W-1]}}, s1_x_q};
    shifted = ext <<< s1_shift_q;
    clip    = 1'b0;
    sat_val = shifted[DATA_W-1:0];
    if (shifted > PosLim) begin
      clip    = 1'b1;
      sat_val = PosLim[DATA_W-1:0];
    end else if (shifted < NegLim) begin
      clip    = 1'b1;
      sat_val = NegLim[DATA_W-1:0];
    end
  end

  always_comb begin
    y_d   = s1_valid_q ? sat_val : y_q;
    out_d = s1_valid_q;
    // A clipping update wins over a simultaneous clear.
    sat_d = (s1_valid_q & clip) | (sat_q & ~sat_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_shift_q <= '0;
      y_q        <= '0;
      out_q      <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_shift_q <= s1_shift_d;
      y_q        <= y_d;
      out_q      <= out_d;
      sat_q      <= sat_d;
    end
  end

  assign y          = y_q;
  assign clk_en_out = out_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_hb_decim_2.sv
// Self-checking bench for hb_decim_2: directed scenarios plus random traffic,
// scored against a strobe-counting reference model through an expectation queue.
module tb_hb_decim_2;

  localparam int DW     = 18;
  localparam int SW     = 2;
  localparam int MAXPOS = 2**(DW-1) - 1;
  localparam int MINNEG = -(2**(DW-1));

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clk_en = 1'b0;
  logic [DW-1:0] x_in = '0;
  logic          phase_sel = 1'b0;
  logic          resync = 1'b0;
  logic [SW-1:0] gain_shl = '0;
  logic          sat_clr = 1'b0;
  logic [DW-1:0] y;
  logic          clk_en_out;
  logic          sat_flag;

  always #5 clk = ~clk;

  hb_decim_2 #(.DATA_W(DW), .SHIFT_W(SW)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .x_in       (x_in),
    .phase_sel  (phase_sel),
    .resync     (resync),
    .gain_shl   (gain_shl),
    .sat_clr    (sat_clr),
    .y          (y),
    .clk_en_out (clk_en_out),
    .sat_flag   (sat_flag)
  );

  typedef struct {
    int yv;
    bit clip;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   slot = 0;     // strobes seen since reset/resync
  int   n_chk = 0;
  int   n_pass = 0;
  bit   clr_s = 1'b0;
  bit   rst_s = 1'b0;
  int   y_m = 0;
  bit   sat_m = 1'b0;

  function automatic void check(string name, int act, int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp_v);
  endfunction

  // Expected result of a kept sample: exact product, clamped to the output range.
  function automatic void push(int x, int g);
    exp_t e;
    int   v;
    v = x * (1 << g);
    e.clip = 1'b1;
    if (v > MAXPOS) e.yv = MAXPOS;
    else if (v < MINNEG) e.yv = MINNEG;
    else begin
      e.yv   = v;
      e.clip = 1'b0;
    end
    e.cyc = cyc + 2;
    q.push_back(e);
  endfunction

  // Inputs are applied just after edge 'cyc' and sampled on edge cyc+1.
  task automatic drive(bit rst, bit en, int x, bit psel, bit rs, int g, bit clr);
    int idx;
    @(posedge clk);
    #1;
    reset     = rst;
    clk_en    = en;
    x_in      = x[DW-1:0];
    phase_sel = psel;
    resync    = rs;
    gain_shl  = g[SW-1:0];
    sat_clr   = clr;
    if (rst) begin
      slot = 0;
      while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    end else if (en) begin
      idx = rs ? 0 : slot;
      if ((idx % 2) == int'(psel)) push(x, g);
      slot = idx + 1;
    end else if (rs) begin
      slot = 0;
    end
  endtask

  task automatic idle(int n, bit psel);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, psel, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Edge bookkeeping: cycle count and control inputs as seen by this edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    clr_s = sat_clr;
    rst_s = reset;
  end

  // Monitor: every cycle compare strobe, held y and sat_flag against the model.
  initial forever begin
    exp_t e;
    bit   due;
    @(negedge clk);
    if (cyc >= 1) begin
      due = 1'b0;
      if (rst_s) begin
        y_m   = 0;
        sat_m = 1'b0;
      end else begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          e   = q.pop_front();
          due = 1'b1;
          y_m = e.yv;
        end
        if (due && e.clip) sat_m = 1'b1;
        else if (clr_s) sat_m = 1'b0;
      end
      check("clk_en_out", int'(clk_en_out), int'(due));
      check("y", int'($signed(y)), y_m);
      check("sat_flag", int'(sat_flag), int'(sat_m));
    end
  end

  initial begin
    int x;
    bit ps;
    repeat (3) do_reset();

    // Continuous strobes, keep phase 0: 1,3,5,7.
    for (int i = 1; i <= 8; i++) drive(1'b0, 1'b1, i, 1'b0, 1'b0, 0, 1'b0);
    idle(3, 1'b0);

    // Keep phase 1: 2,4,6,8.
    do_reset();
    for (int i = 1; i <= 8; i++) drive(1'b0, 1'b1, i, 1'b1, 1'b0, 0, 1'b0);
    idle(3, 1'b1);

    // Strobe every third cycle.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, i, 1'b1, 1'b0, 0, 1'b0);
      idle(2, 1'b1);
    end
    idle(2, 1'b1);

    // Gain of 4 with clipping in both directions and an exact negative limit.
    do_reset();
    drive(1'b0, 1'b1, 1000, 1'b0, 1'b0, 2, 1'b0);
    drive(1'b0, 1'b1, 7, 1'b0, 1'b0, 2, 1'b0);
    drive(1'b0, 1'b1, 40000, 1'b0, 1'b0, 2, 1'b0);
    drive(1'b0, 1'b1, 7, 1'b0, 1'b0, 2, 1'b0);
    drive(1'b0, 1'b1, -40000, 1'b0, 1'b0, 2, 1'b0);
    drive(1'b0, 1'b1, 7, 1'b0, 1'b0, 2, 1'b0);
    drive(1'b0, 1'b1, -32768, 1'b0, 1'b0, 2, 1'b0);
    drive(1'b0, 1'b1, 7, 1'b0, 1'b0, 2, 1'b0);
    idle(3, 1'b0);

    // Clear alone, then clear on the same edge as a clipping output.
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    idle(2, 1'b0);
    drive(1'b0, 1'b1, 131071, 1'b0, 1'b0, 3, 1'b0);
    drive(1'b0, 1'b1, 5, 1'b0, 1'b0, 3, 1'b1);
    idle(3, 1'b0);

    // Resync on an odd slot: 49, 50, 52.
    do_reset();
    drive(1'b0, 1'b1, 49, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b1, 50, 1'b0, 1'b1, 0, 1'b0);
    drive(1'b0, 1'b1, 51, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b1, 52, 1'b0, 1'b0, 0, 1'b0);
    idle(3, 1'b0);

    // Resync without a strobe: next strobe is phase 0.
    drive(1'b0, 1'b1, 60, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1, 0, 1'b0);
    drive(1'b0, 1'b1, 61, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b1, 62, 1'b0, 1'b0, 0, 1'b0);
    idle(3, 1'b0);

    // Reset between capture and output squashes the sample.
    drive(1'b0, 1'b1, 131071, 1'b0, 1'b0, 3, 1'b0);
    idle(3, 1'b0);
    drive(1'b0, 1'b1, 77, 1'b0, 1'b1, 0, 1'b0);
    do_reset();
    idle(2, 1'b0);
    drive(1'b0, 1'b1, 88, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b1, 89, 1'b0, 1'b0, 0, 1'b0);
    idle(3, 1'b0);

    // Random traffic.
    ps = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      x = int'($urandom_range(0, 2**DW - 1)) - 2**(DW-1);
      if ($urandom_range(0, 4) == 0) x = x / 64;
      if ($urandom_range(0, 49) == 0) ps = ~ps;
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), x, ps,
            ($urandom_range(0, 29) == 0), int'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0));
    end
    idle(4, ps);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
